stride_vp_top: RTL

Multi-lane, parametrised stride value predictor; next generation of the last-value predictor in the `vp` tree. Each entry stores last value, stride, confidence and, optionally, a PC tag, so constant and arithmetic-progression results are predicted. Sits between fetch/decode (forward PC lanes) and writeback (feedback lanes), with write-first bypass and deterministic multi-lane write arbitration.

---
 rtl/stride_vp_top.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/stride_vp_top.sv
// stride_vp_top: multi-lane stride value predictor.
// Each entry holds the last value, the stride, a confidence counter and,
// when STRIDE_VP_TAG_EN is defined, a PC tag. Forward lanes read the table
// with a 1-cycle registered latency. Feedback lanes update it at the clock
// edge. Same-cycle feedback is bypassed write-first into forward reads.
// Optional feature macro: STRIDE_VP_TAG_EN (tag storage and compare).
module stride_vp_top #(
   parameter int unsigned P_STORAGE_SIZE = 1024,
   parameter int unsigned P_DATA_WIDTH   = 32,
   parameter int unsigned P_TAG_WIDTH    = 8,
   parameter int unsigned P_CONF_WIDTH   = 3,
   parameter int unsigned P_CONF_THRES   = 4,
   parameter int unsigned P_NUM_PRED     = 2
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic [P_NUM_PRED-1:0][31:0]              fw_pc_i,
   input  logic [P_NUM_PRED-1:0]                    fw_valid_i,
   output logic [P_NUM_PRED-1:0][31:0]              pred_pc_o,
   output logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0]  pred_result_o,
   output logic [P_NUM_PRED-1:0][P_CONF_WIDTH-1:0]  pred_conf_o,
   output logic [P_NUM_PRED-1:0]                    pred_valid_o,
   input  logic [P_NUM_PRED-1:0][31:0]              fb_pc_i,
   input  logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0]  fb_actual_i,
   input  logic [P_NUM_PRED-1:0]                    fb_valid_i
);

   localparam int unsigned P_INDEX_WIDTH = $clog2(P_STORAGE_SIZE);
   localparam logic [P_CONF_WIDTH-1:0] C_CONF_MAX   = '1;
   localparam logic [P_CONF_WIDTH-1:0] C_CONF_THRES = P_CONF_WIDTH'(P_CONF_THRES);
   localparam logic [P_CONF_WIDTH-1:0] C_CONF_ONE   = P_CONF_WIDTH'(1);

   // Table storage; only the valid bits are reset.
   logic [P_DATA_WIDTH-1:0] last_q   [P_STORAGE_SIZE];
   logic [P_DATA_WIDTH-1:0] stride_q [P_STORAGE_SIZE];
   logic [P_CONF_WIDTH-1:0] conf_q   [P_STORAGE_SIZE];
   logic [P_STORAGE_SIZE-1:0] valid_q;

   // Per-lane index decode.
   logic [P_NUM_PRED-1:0][P_INDEX_WIDTH-1:0] fb_idx;
   logic [P_NUM_PRED-1:0][P_INDEX_WIDTH-1:0] fw_idx;

   // Feedback update datapath.
   logic [P_NUM_PRED-1:0]                    fb_hit;
   logic [P_NUM_PRED-1:0]                    fb_win;
   logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0]  fb_new_stride;
   logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0]  upd_last;
   logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0]  upd_stride;
   logic [P_NUM_PRED-1:0][P_CONF_WIDTH-1:0]  upd_conf;

   // Forward read datapath (after bypass).
   logic [P_NUM_PRED-1:0]                    rd_valid;
   logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0]  rd_last;
   logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0]  rd_stride;
   logic [P_NUM_PRED-1:0][P_CONF_WIDTH-1:0]  rd_conf;
   logic [P_NUM_PRED-1:0]                    rd_hit;
   logic [P_NUM_PRED-1:0][P_DATA_WIDTH-1:0]  nxt_result;
   logic [P_NUM_PRED-1:0][P_CONF_WIDTH-1:0]  nxt_conf;
   logic [P_NUM_PRED-1:0]                    nxt_valid;

   // Only the index (and tag) bits of the feedback PC are consumed.
   logic unused_fb_pc;
   assign unused_fb_pc = ^fb_pc_i;

`ifdef STRIDE_VP_TAG_EN
   logic [P_TAG_WIDTH-1:0] tag_q [P_STORAGE_SIZE];
   logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0] fb_tag;
   logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0] fw_tag;
   logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0] rd_tag;
`else
   localparam int unsigned unused_tag_width = P_TAG_WIDTH;
`endif

   // Index and tag extraction for every lane.
   always_comb begin
      fb_idx = '0;
      fw_idx = '0;
`ifdef STRIDE_VP_TAG_EN
      fb_tag = '0;
      fw_tag = '0;
`endif
      for (int unsigned l = 0; l < P_NUM_PRED; l++) begin
         fb_idx[l] = fb_pc_i[l][P_INDEX_WIDTH+1:2];
         fw_idx[l] = fw_pc_i[l][P_INDEX_WIDTH+1:2];
`ifdef STRIDE_VP_TAG_EN
         fb_tag[l] = fb_pc_i[l][P_INDEX_WIDTH+P_TAG_WIDTH+1 -: P_TAG_WIDTH];
         fw_tag[l] = fw_pc_i[l][P_INDEX_WIDTH+P_TAG_WIDTH+1 -: P_TAG_WIDTH];
`endif
      end
   end

   // Feedback: compute each lane's post-update entry and arbitrate same-index lanes.
   always_comb begin
      fb_hit        = '0;
      fb_win        = '0;
      fb_new_stride = '0;
      upd_last      = '0;
      upd_stride    = '0;
      upd_conf      = '0;
      for (int unsigned l = 0; l < P_NUM_PRED; l++) begin
`ifdef STRIDE_VP_TAG_EN
         fb_hit[l] = valid_q[fb_idx[l]] && (tag_q[fb_idx[l]] == fb_tag[l]);
`else
         fb_hit[l] = valid_q[fb_idx[l]];
`endif
         fb_new_stride[l] = fb_actual_i[l] - last_q[fb_idx[l]];
         upd_last[l]      = fb_actual_i[l];
         if (!fb_hit[l]) begin
            upd_stride[l] = '0;
            upd_conf[l]   = '0;
         end else if (fb_new_stride[l] == stride_q[fb_idx[l]]) begin
            upd_stride[l] = stride_q[fb_idx[l]];
            upd_conf[l]   = (conf_q[fb_idx[l]] == C_CONF_MAX) ? C_CONF_MAX
                                                              : conf_q[fb_idx[l]] + C_CONF_ONE;
         end else begin
            upd_stride[l] = fb_new_stride[l];
            upd_conf[l]   = '0;
         end
         // A higher-numbered lane on the same index drops this lane entirely.
         fb_win[l] = fb_valid_i[l];
         for (int unsigned h = l + 1; h < P_NUM_PRED; h++) begin
            if (fb_valid_i[h] && (fb_idx[h] == fb_idx[l])) begin
               fb_win[l] = 1'b0;
            end
         end
      end
   end

   // Forward: table read with write-first bypass from the winning feedback lane.
   always_comb begin
      rd_valid   = '0;
      rd_last    = '0;
      rd_stride  = '0;
      rd_conf    = '0;
      rd_hit     = '0;
      nxt_result = '0;
      nxt_conf   = '0;
      nxt_valid  = '0;
`ifdef STRIDE_VP_TAG_EN
      rd_tag     = '0;
`endif
      for (int unsigned f = 0; f < P_NUM_PRED; f++) begin
         rd_valid[f]  = valid_q[fw_idx[f]];
         rd_last[f]   = last_q[fw_idx[f]];
         rd_stride[f] = stride_q[fw_idx[f]];
         rd_conf[f]   = conf_q[fw_idx[f]];
`ifdef STRIDE_VP_TAG_EN
         rd_tag[f]    = tag_q[fw_idx[f]];
`endif
         // Winners have distinct indices, so at most one lane matches here.
         for (int unsigned l = 0; l < P_NUM_PRED; l++) begin
            if (fb_win[l] && (fb_idx[l] == fw_idx[f])) begin
               rd_valid[f]  = 1'b1;
               rd_last[f]   = upd_last[l];
               rd_stride[f] = upd_stride[l];
               rd_conf[f]   = upd_conf[l];
`ifdef STRIDE_VP_TAG_EN
               rd_tag[f]    = fb_tag[l];
`endif
            end
         end
`ifdef STRIDE_VP_TAG_EN
         rd_hit[f] = rd_valid[f] && (rd_tag[f] == fw_tag[f]);
`else
         rd_hit[f] = rd_valid[f];
`endif
         nxt_result[f] = rd_hit[f] ? (rd_last[f] + rd_stride[f]) : '0;
         nxt_conf[f]   = rd_hit[f] ? rd_conf[f] : '0;
         nxt_valid[f]  = fw_valid_i[f] && rd_hit[f] && (rd_conf[f] >= C_CONF_THRES);
      end
   end

   // Table payload write for winning feedback lanes.
   always_ff @(posedge clk_i) begin
      for (int unsigned l = 0; l < P_NUM_PRED; l++) begin
         if (fb_win[l]) begin
            last_q[fb_idx[l]]   <= upd_last[l];
            stride_q[fb_idx[l]] <= upd_stride[l];
            conf_q[fb_idx[l]]   <= upd_conf[l];
`ifdef STRIDE_VP_TAG_EN
            tag_q[fb_idx[l]]    <= fb_tag[l];
`endif
         end
      end
   end

   // Valid bits: cleared by reset, set on allocation or update.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else begin
         for (int unsigned l = 0; l < P_NUM_PRED; l++) begin
            if (fb_win[l]) begin
               valid_q[fb_idx[l]] <= 1'b1;
            end
         end
      end
   end

   // Registered prediction outputs, cleared immediately by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pred_pc_o     <= '0;
         pred_result_o <= '0;
         pred_conf_o   <= '0;
         pred_valid_o  <= '0;
      end else begin
         pred_pc_o     <= fw_pc_i;
         pred_result_o <= nxt_result;
         pred_conf_o   <= nxt_conf;
         pred_valid_o  <= nxt_valid;
      end
   end

endmodule
